// File: rtl/axi_pkg.sv
// axi_pkg: burst/response codes, FSM states and address context shared by the AXI SRAM responder.
package axi_pkg;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] BURST_WRAP = 2'b10;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR_DATA, WR_RESP} state_t;
  typedef struct packed {
    logic [3:0] id;
    logic [31:0] addr;
    logic [3:0] len;
    logic [1:0] burst;
  } axi_addr_ctx_t;
endpackage

// File: rtl/axi_burst_addr_gen.sv
// axi_burst_addr_gen: next beat address for FIXED/INCR/WRAP bursts; illegal WRAP lengths and type 11 act as INCR.
module axi_burst_addr_gen
  import axi_pkg::*;
(
  input axi_addr_ctx_t ctx,
  input logic [31:0] addr,
  output logic [31:0] next_addr
);
  logic [31:0] inc, mask;
  logic wrap;
  always_comb begin
    inc = addr + 32'd4;
    mask = {26'd0, ctx.len, 2'b11};
    wrap = ctx.burst == BURST_WRAP && ctx.len inside {4'd1, 4'd3, 4'd7, 4'd15};
    next_addr = ctx.burst == BURST_FIXED ? addr : wrap ? (addr & ~mask) | (inc & mask) : inc;
  end
endmodule

// File: rtl/axi_sram_responder.sv
// axi_sram_responder: AXI3 slave serving one burst at a time from a 1-cycle-latency word SRAM.
// Define AXI_RESP_ERR_EN to answer SLVERR for out-of-range addresses and non-word sizes.
module axi_sram_responder
  import axi_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter bit RESET_PRIO_RD = 1'b1
) (
  input logic aclk,
  input logic areset,
  input logic [3:0] arid,
  input logic [31:0] araddr,
  input logic [3:0] arlen,
  input logic [2:0] arsize,
  input logic [1:0] arburst,
  input logic [1:0] arlock,
  input logic [3:0] arcache,
  input logic [2:0] arprot,
  input logic arvalid,
  output logic arready,
  output logic [3:0] rid,
  output logic [31:0] rdata,
  output logic [1:0] rresp,
  output logic rlast,
  output logic rvalid,
  input logic rready,
  input logic [3:0] awid,
  input logic [31:0] awaddr,
  input logic [3:0] awlen,
  input logic [2:0] awsize,
  input logic [1:0] awburst,
  input logic [1:0] awlock,
  input logic [3:0] awcache,
  input logic [2:0] awprot,
  input logic awvalid,
  output logic awready,
  input logic [3:0] wid,
  input logic [31:0] wdata,
  input logic [3:0] wstrb,
  input logic wlast,
  input logic wvalid,
  output logic wready,
  output logic [3:0] bid,
  output logic [1:0] bresp,
  output logic bvalid,
  input logic bready,
  output logic sram_en,
  output logic [3:0] sram_wen,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0] sram_wdata,
  input logic [31:0] sram_rdata
);
  state_t state;
  axi_addr_ctx_t ctx;
  logic [3:0] cnt;
  logic [31:0] rdata_q, next_addr;
  logic prio_rd, rd_fresh, wr_err, beat_err, ar_win, aw_win, last, unused;

  axi_burst_addr_gen u_addr_gen (.ctx(ctx), .addr(ctx.addr), .next_addr(next_addr));

`ifdef AXI_RESP_ERR_EN
  logic size_bad;
  assign beat_err = size_bad || |ctx.addr[31:ADDR_W];
  always_ff @(posedge aclk or posedge areset)
    if (areset) size_bad <= 1'b0;
    else if (arready) size_bad <= arsize != 3'b010;
    else if (awready) size_bad <= awsize != 3'b010;
`else
  assign beat_err = 1'b0;
`endif

  assign ar_win = arvalid && (!awvalid || prio_rd);
  assign aw_win = awvalid && (!arvalid || !prio_rd);
  assign arready = state == IDLE && ar_win;
  assign awready = state == IDLE && aw_win;
  assign last = cnt == ctx.len;
  assign rvalid = state == RD_DATA;
  assign rlast = rvalid && last;
  assign rid = ctx.id;
  assign rresp = rvalid && beat_err ? RESP_SLVERR : RESP_OKAY;
  // SRAM data is valid only in the first RD_DATA cycle; afterwards the captured copy is held.
  assign rdata = rd_fresh ? (beat_err ? 32'd0 : sram_rdata) : rdata_q;
  assign wready = state == WR_DATA;
  assign bvalid = state == WR_RESP;
  assign bid = ctx.id;
  assign bresp = bvalid && wr_err ? RESP_SLVERR : RESP_OKAY;
  assign sram_en = !beat_err && (state == RD_REQ || (wready && wvalid));
  assign sram_wen = sram_en && wready ? wstrb : 4'd0;
  assign sram_addr = {ctx.addr[ADDR_W-1:2], 2'b00};
  assign sram_wdata = wdata;
  assign unused = ^{arlock, arcache, arprot, arsize, awlock, awcache, awprot, awsize, wid, wlast};

  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      state <= IDLE;
      ctx <= '0;
      cnt <= '0;
      prio_rd <= RESET_PRIO_RD;
      rd_fresh <= 1'b0;
      rdata_q <= '0;
      wr_err <= 1'b0;
    end else begin
      rd_fresh <= state == RD_REQ;
      if (rvalid) rdata_q <= rdata;
      case (state)
        IDLE: if (ar_win || aw_win) begin
          ctx <= ar_win ? '{arid, araddr, arlen, arburst} : '{awid, awaddr, awlen, awburst};
          cnt <= '0;
          wr_err <= 1'b0;
          prio_rd <= !prio_rd;
          state <= ar_win ? RD_REQ : WR_DATA;
        end
        RD_REQ: state <= RD_DATA;
        RD_DATA: if (rready) begin
          state <= last ? IDLE : RD_REQ;
          if (!last) begin
            cnt <= cnt + 4'd1;
            ctx.addr <= next_addr;
          end
        end
        WR_DATA: if (wvalid) begin
          wr_err <= wr_err || beat_err;
          state <= last ? WR_RESP : WR_DATA;
          if (!last) begin
            cnt <= cnt + 4'd1;
            ctx.addr <= next_addr;
          end
        end
        WR_RESP: if (bready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_axi_sram_responder.sv
// tb_axi_sram_responder: directed read/write bursts against a behavioural 1-cycle SRAM.
module tb_axi_sram_responder;
  import axi_pkg::*;
  localparam int ADDR_W = 16;

  logic aclk = 1'b0, areset = 1'b1;
  logic [3:0] arid = '0, arlen = '0, arcache = '0, awid = '0, awlen = '0, awcache = '0, wid = '0, wstrb = '0;
  logic [31:0] araddr = '0, awaddr = '0, wdata = '0, sram_rdata = '0;
  logic [2:0] arsize = 3'b010, arprot = '0, awsize = 3'b010, awprot = '0;
  logic [1:0] arburst = '0, arlock = '0, awburst = '0, awlock = '0;
  logic arvalid = 0, rready = 0, awvalid = 0, wlast = 0, wvalid = 0, bready = 0;
  logic arready, rlast, rvalid, awready, wready, bvalid, sram_en;
  logic [3:0] rid, bid, sram_wen;
  logic [31:0] rdata, sram_wdata;
  logic [1:0] rresp, bresp;
  logic [ADDR_W-1:0] sram_addr;

  always #5 aclk = ~aclk;

  axi_sram_responder #(.ADDR_W(ADDR_W), .RESET_PRIO_RD(1'b1)) dut (
    .aclk(aclk), .areset(areset),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  logic [31:0] mem [0:16383];
  always @(posedge aclk)
    if (sram_en) begin
      if (sram_wen == 4'd0) sram_rdata <= mem[sram_addr[15:2]];
      for (int i = 0; i < 4; i++)
        if (sram_wen[i]) mem[sram_addr[15:2]][i*8 +: 8] = sram_wdata[i*8 +: 8];
    end

  logic [15:0] rd_addrs[$];
  int bhs = 0, en_cnt = 0;
  always @(posedge aclk) begin
    if (sram_en && sram_wen == 4'd0) rd_addrs.push_back(sram_addr);
    if (bvalid && bready) bhs++;
    if (sram_en) en_cnt++;
  end

  int errors = 0, checks = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [3:0] id;
    logic [31:0] addr;
    logic [3:0] len;
    logic [1:0] burst;
    logic [3:0] stall;
    logic [3:0][15:0] ea;
  } rd_vec_t;

  function automatic rd_vec_t mk(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                                 input logic [1:0] burst, input logic [3:0] stall,
                                 input logic [15:0] a0, a1, a2, a3);
    rd_vec_t v;
    v.id = id; v.addr = addr; v.len = len; v.burst = burst; v.stall = stall;
    v.ea[0] = a0; v.ea[1] = a1; v.ea[2] = a2; v.ea[3] = a3;
    return v;
  endfunction

  function automatic logic [31:0] exp_word(input logic [15:0] a);
    return a == 16'h0100 ? 32'hDEADBEEF : 32'h5A000000 | {16'h0, a};
  endfunction

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst);
    int n;
    n = 0;
    rd_addrs.delete();
    arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1; #1;
    while (!arready && n < 20) begin @(negedge aclk); #1; n++; end
    chk("arready", arready, 1);
    @(negedge aclk);
    arvalid = 0;
  endtask

  task automatic recv(input logic [3:0] id, input logic [3:0] len, input logic [3:0] stall,
                      input logic [3:0][15:0] ea, input logic [3:0][31:0] ed,
                      input logic [1:0] resp, input int nacc);
    int n;
    for (int b = 0; b <= int'(len); b++) begin
      n = 0;
      #1;
      while (!rvalid && n < 20) begin @(negedge aclk); #1; n++; end
      chk("rvalid", rvalid, 1);
      if (b == int'(stall)) begin
        repeat (3) @(negedge aclk);
        #1;
        chk("rvalid_stall", rvalid, 1);
        chk("rdata_stall", rdata, ed[b]);
      end
      chk("rdata", rdata, ed[b]);
      chk("rid", rid, id);
      chk("rresp", rresp, resp);
      chk("rlast", rlast, b == int'(len));
      rready = 1;
      @(negedge aclk);
      rready = 0;
    end
    chk("n_sram_reads", rd_addrs.size(), nacc);
    for (int b = 0; b < nacc && b < rd_addrs.size(); b++) chk("sram_addr", rd_addrs[b], ea[b]);
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [1:0][31:0] d, input logic [1:0][3:0] s);
    int n;
    n = 0;
    awid = id; awaddr = addr; awlen = len; awburst = BURST_INCR; awvalid = 1; #1;
    while (!awready && n < 20) begin @(negedge aclk); #1; n++; end
    chk("awready", awready, 1);
    @(negedge aclk);
    awvalid = 0;
    for (int b = 0; b <= int'(len); b++) begin
      wvalid = 1; wdata = d[b]; wstrb = s[b]; #1;
      n = 0;
      while (!wready && n < 20) begin @(negedge aclk); #1; n++; end
      chk("wready", wready, 1);
      @(negedge aclk);
      wvalid = 0;
    end
    n = 0;
    #1;
    while (!bvalid && n < 20) begin @(negedge aclk); #1; n++; end
    chk("bvalid", bvalid, 1);
    chk("bid", bid, id);
    chk("bresp", bresp, RESP_OKAY);
    bready = 1;
    @(negedge aclk);
    bready = 0;
    repeat (3) @(negedge aclk);
  endtask

  rd_vec_t tv [7];
  logic [3:0][15:0] ea;
  logic [3:0][31:0] ed;
  logic [1:0][31:0] wd;
  logic [1:0][3:0] ws;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < 16384; i++) mem[i] = 32'h5A000000 | (i << 2);
    mem[64] = 32'hDEADBEEF;
    tv[0] = mk(3, 32'h100, 0, BURST_INCR, 4'hF, 16'h100, 0, 0, 0);
    tv[1] = mk(1, 32'h40, 3, BURST_INCR, 1, 16'h40, 16'h44, 16'h48, 16'h4C);
    tv[2] = mk(2, 32'h1C, 3, BURST_WRAP, 4'hF, 16'h1C, 16'h10, 16'h14, 16'h18);
    tv[3] = mk(4, 32'h200, 2, BURST_FIXED, 4'hF, 16'h200, 16'h200, 16'h200, 0);
    tv[4] = mk(6, 32'h30, 2, BURST_WRAP, 4'hF, 16'h30, 16'h34, 16'h38, 0);
    tv[5] = mk(7, 32'h3C, 1, BURST_WRAP, 4'hF, 16'h3C, 16'h38, 0, 0);
    tv[6] = mk(8, 32'hF4, 3, 2'b11, 4'hF, 16'hF4, 16'hF8, 16'hFC, 16'h100);

    repeat (2) @(negedge aclk);
    #1;
    chk("rst_rvalid", rvalid, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_wready", wready, 0);
    chk("rst_sram_en", sram_en, 0);
    chk("rst_sram_wen", sram_wen, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rid", rid, 0);
    chk("rst_bid", bid, 0);
    @(negedge aclk);
    areset = 0;
    @(negedge aclk);

    // both channels valid from reset: read first, then write
    rd_addrs.delete();
    arid = 9; araddr = 32'h100; arlen = 0; arburst = BURST_INCR; arvalid = 1;
    awid = 10; awaddr = 32'h90; awlen = 0; awburst = BURST_INCR; awvalid = 1; #1;
    chk("arb1_arready", arready, 1);
    chk("arb1_awready", awready, 0);
    @(negedge aclk);
    arvalid = 0; awvalid = 0;
    ea = '0; ed = '0; ea[0] = 16'h100; ed[0] = 32'hDEADBEEF;
    recv(9, 0, 4'hF, ea, ed, RESP_OKAY, 1);
    arvalid = 1; awvalid = 1; #1;
    chk("arb2_arready", arready, 0);
    chk("arb2_awready", awready, 1);
    arvalid = 0;
    wd = '0; ws = '0; wd[0] = 32'h01020304; ws[0] = 4'hF;
    bhs = 0;
    do_write(10, 32'h90, 0, wd, ws);
    chk("arb_bvalid_once", bhs, 1);
    chk("arb_mem", mem[16'h90 >> 2], 32'h01020304);

    for (int i = 0; i < 7; i++) begin
      for (int b = 0; b < 4; b++) ed[b] = exp_word(tv[i].ea[b]);
      send_ar(tv[i].id, tv[i].addr, tv[i].len, tv[i].burst);
      recv(tv[i].id, tv[i].len, tv[i].stall, tv[i].ea, ed, RESP_OKAY, int'(tv[i].len) + 1);
    end

    wd[0] = 32'h11223344; ws[0] = 4'b0011;
    wd[1] = 32'hAABBCCDD; ws[1] = 4'b1111;
    bhs = 0;
    do_write(5, 32'h80, 1, wd, ws);
    chk("wr_bvalid_once", bhs, 1);
    ea = '0; ed = '0;
    ea[0] = 16'h80; ea[1] = 16'h84; ed[0] = 32'h5A003344; ed[1] = 32'hAABBCCDD;
    send_ar(12, 32'h80, 1, BURST_INCR);
    recv(12, 1, 4'hF, ea, ed, RESP_OKAY, 2);

`ifndef AXI_RESP_ERR_EN
    ea[0] = 16'hFFF8; ea[1] = 16'hFFFC; ea[2] = 16'h0000; ea[3] = 16'h0004;
    for (int b = 0; b < 4; b++) ed[b] = exp_word(ea[b]);
    send_ar(13, 32'hFFF8, 3, BURST_INCR);
    recv(13, 3, 4'hF, ea, ed, RESP_OKAY, 4);
`else
    ea = '0; ed = '0;
    en_cnt = 0;
    send_ar(13, 32'h0001_0000, 0, BURST_INCR);
    recv(13, 0, 4'hF, ea, ed, RESP_SLVERR, 0);
    chk("err_sram_en", en_cnt, 0);
`endif

    // reset in the middle of an 8-beat read
    send_ar(14, 32'h0, 7, BURST_INCR);
    n = 0;
    #1;
    while (!rvalid && n < 20) begin @(negedge aclk); #1; n++; end
    chk("mid_rvalid", rvalid, 1);
    areset = 1; #1;
    chk("mid_rst_rvalid", rvalid, 0);
    chk("mid_rst_sram_en", sram_en, 0);
    @(negedge aclk);
    areset = 0;
    @(negedge aclk);
    ea = '0; ed = '0; ea[0] = 16'h100; ed[0] = 32'hDEADBEEF;
    send_ar(15, 32'h100, 0, BURST_INCR);
    recv(15, 0, 4'hF, ea, ed, RESP_OKAY, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axi_sram_responder.md
Name: axi_sram_responder

Overview:
AXI3 slave that terminates an initiator-side AXI bus and serves it from a single-port synchronous word SRAM with 1-cycle read latency.
- Used as the memory model behind the CPU's bus-to-AXI converter in simulation and in the bare test SoC.
- Serves one transaction at a time, either a read burst or a write burst, with no outstanding-transaction overlap.

Parameters:
- ADDR_W, 16: SRAM byte-address width; memory size is 2^ADDR_W bytes.
- RESET_PRIO_RD, 1: initial arbitration winner after reset (1 = read).

Ports:
- aclk  input  1  clock
- areset  input  1  asynchronous reset, active-high
- arid, arlen  input  4 each  read ID, beats-1
- araddr  input  32  read start address
- arsize  input  3  beat size
- arburst  input  2  burst type
- arlock, arcache, arprot  input  2/4/3  accepted, ignored
- arvalid  input  1;  arready  output  1
- rid  output  4;  rdata  output  32;  rresp  output  2;  rlast  output  1;  rvalid  output  1;  rready  input  1
- awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid  inputs, same widths as AR
- awready  output  1
- wid  input  4 (ignored);  wdata  input  32;  wstrb  input  4;  wlast  input  1 (ignored);  wvalid  input  1;  wready  output  1
- bid  output  4;  bresp  output  2;  bvalid  output  1;  bready  input  1
- sram_en  output  1;  sram_wen  output  4;  sram_addr  output  ADDR_W;  sram_wdata  output  32;  sram_rdata  input  32

Behaviour:
- Reset (async, any state): state=IDLE. All valids/readys=0, sram_en=0, sram_wen=0, beat counter=0, priority=RESET_PRIO_RD. rid/bid/rdata/rresp/bresp=0.
- FSM states: IDLE, RD_REQ, RD_DATA, WR_DATA, WR_RESP.
- IDLE:
  - arready/awready are driven combinationally high only toward the arbitration winner.
  - Winner: the only valid channel. If arvalid and awvalid are both high, the priority flag decides, and the flag toggles after every accepted address (round-robin).
  - On handshake, latch id, addr, len, burst; beat counter=0. Go to RD_REQ or WR_DATA.
- RD_REQ:
  - sram_en=1, sram_wen=0, sram_addr=beat address[ADDR_W-1:2],2'b00.
  - Next cycle go to RD_DATA.
- RD_DATA:
  - rvalid=1. rdata is registered from sram_rdata and held stable while rready=0.
  - rid=latched id, rresp=OKAY(00), rlast=(counter==len).
  - On rready: if last, go to IDLE; else counter++, advance address, go to RD_REQ.
  - Throughput: 1 beat per 2 cycles min.
- WR_DATA:
  - wready=1. On wvalid: sram_en=1, sram_wen=wstrb, sram_wdata=wdata, same cycle.
  - If counter==len, go to WR_RESP; else counter++ and advance address.
  - Burst length comes from awlen only; wlast is not checked.
- WR_RESP:
  - bvalid=1, bid=latched id, bresp=OKAY.
  - On bready, go to IDLE.
- Address advance:
  - FIXED(00): address unchanged.
  - INCR(01): +4, 32-bit wrap-around.
  - WRAP(10): +4 within a (len+1)*4-byte aligned window. Legal only for len in {1,3,7,15}; any other len is treated as INCR.
  - Burst type 11 is treated as INCR.
- Size: every beat is a 32-bit word; arsize/awsize are ignored and the low 2 address bits are dropped.
- Addresses above 2^ADDR_W alias modulo the memory size.
- No new address is accepted until the current response completes.

Optional Feature:
- Macro AXI_RESP_ERR_EN.
- Defined:
  - A beat whose address[31:ADDR_W]!=0 suppresses its SRAM access (sram_en=0) and returns resp=SLVERR(10). For such read beats, rdata=0.
  - bresp=SLVERR if any beat in the write burst was out of range.
  - A size other than 3'b010 also yields SLVERR on every beat.
- Undefined: always OKAY, addresses alias as described in Behaviour.

Decomposition:
- Shared package axi_pkg:
  - burst-type constants FIXED/INCR/WRAP
  - resp constants OKAY/SLVERR
  - FSM state enum
  - typedef axi_addr_ctx_t {id, addr, len, burst}
- Sub-module axi_burst_addr_gen (combinational next-address from ctx + current address); reused by the read and write paths.

Test Plan:
- Single read: preload word 0x100=0xDEADBEEF; AR addr=0x100, len=0, id=3 -> one beat rdata=0xDEADBEEF, rid=3, rlast=1, rresp=00.
- INCR read with backpressure: AR addr=0x40, len=3; rready low for 3 cycles on beat 2 -> rdata stable while stalled; sram_addr order 0x40,0x44,0x48,0x4C; rlast only on beat 4.
- WRAP read: addr=0x1C, len=3, burst=10 -> addresses 0x1C,0x10,0x14,0x18.
- Strobed write: AW addr=0x80, len=1, id=5; W 0x11223344 strb=0011, then 0xAABBCCDD strb=1111 -> read back 0x80 = old[31:16],3344 and 0x84=0xAABBCCDD; bid=5, bresp=00; bvalid exactly once.
- Arbitration: arvalid and awvalid asserted together from reset -> read served first; both asserted again -> write served next.
- Reset mid-burst: assert areset during RD_DATA of an 8-beat burst -> rvalid=0 immediately, IDLE after release, and a fresh AR is served correctly. With AXI_RESP_ERR_EN, read of 0x0001_0000 (ADDR_W=16) -> rresp=10, rdata=0, sram_en never asserted.
